fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream consumer of the 16x8 synchronous FIFO. Pops one byte at a time
//  (rd_en / empty / registered output_data) and serialises it as an async
//  UART frame: start bit, WIDTH data bits LSB first, optional even parity,
//  one stop bit. Sits between the FIFO read port and the chip TX pad.
// PARAMETERS
//  WIDTH         8   data bits per frame; equals the FIFO WIDTH
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range >= 2
//  DIV_WIDTH     16  width of the baud counter; 2**DIV_WIDTH > CLKS_PER_BIT
//  PARITY_EN     0   1 inserts an even-parity bit after the data bits
// PORTS
//  clk          in   1      single system clock; all logic on posedge
//  reset        in   1      asynchronous, active-low reset
//  tx_enable    in   1      1 = start new frames; 0 = finish current, then hold
//  fifo_empty   in   1      FIFO empty flag; registered, lags pointers 1 cycle
//  fifo_data    in   WIDTH  FIFO output_data; valid the cycle after rd_en
//  fifo_rd_en   out  1      one-cycle pop strobe to the FIFO
//  tx           out  1      serial line; idle high
//  busy         out  1      1 from POP through the end of STOP
//  frame_done   out  1      one-cycle pulse on the last cycle of STOP
// BEHAVIOUR
//  Reset (reset=0, async): tx=1, fifo_rd_en=0, busy=0, frame_done=0, state=IDLE,
//   shift reg=0, baud cnt=0, bit cnt=0, settle cnt=0. All outputs are registered.
//  Settle: after reset releases, wait 2 cycles before sampling fifo_empty
//   (the flag is not valid in the first cycle out of reset).
//  FSM states: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
//  IDLE: tx=1. If settle done && tx_enable && !fifo_empty -> POP.
//  POP: fifo_rd_en=1 for exactly this one cycle; busy=1 -> LOAD.
//  LOAD: fifo_data is valid this cycle; latch into shift reg at cycle end,
//   clear parity accumulator -> START.
//  START: tx=0 for CLKS_PER_BIT cycles -> DATA.
//  DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right and XOR the
//   bit into parity at the end of each bit; after WIDTH bits -> PARITY if
//   PARITY_EN else STOP.
//  PARITY: tx=XOR of all data bits (even parity), CLKS_PER_BIT cycles -> STOP.
//  STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 on the last cycle -> IDLE.
//  Baud counter: runs 0..CLKS_PER_BIT-1 in START/DATA/PARITY/STOP and
//   reloads 0 on each bit boundary. Every bit is exactly CLKS_PER_BIT cycles.
//  Frame length: (1+WIDTH+PARITY_EN+1)*CLKS_PER_BIT cycles of START..STOP.
//   Back-to-back gap = 3 cycles of tx=1 (IDLE, POP, LOAD) between stop and start.
//  One pop per frame, so the 1-cycle fifo_empty lag never causes an underflow.
//   fifo_rd_en is never asserted while fifo_empty=1 is sampled in IDLE.
//  tx_enable is sampled only in IDLE. Deasserting it mid-frame completes the
//   frame normally; re-asserting it resumes on the next IDLE cycle.
//  fifo_data and fifo_empty are ignored outside the LOAD and IDLE states.
//  Reset mid-frame: the frame is aborted and tx=1 asynchronously. The popped
//   byte is lost; no re-pop occurs. Settle applies again after release.
// TESTING (CLKS_PER_BIT=4 unless noted)
//  1 Reset/idle: reset low then high with FIFO empty -> tx=1, busy=0,
//    fifo_rd_en never asserted for 100 cycles.
//  2 Single byte 0xA5 -> one rd_en pulse; tx=0 for 4 cycles, then
//    1,0,1,0,0,1,0,1 for 4 cycles each, stop=1 for 4; frame_done 40 cycles
//    after START begins.
//  3 Bytes 0x01,0x80,0xFF written back-to-back -> 3 frames in order, exactly
//    3 idle-high cycles between each stop and the next start, 3 rd_en pulses.
//  4 PARITY_EN=1, byte 0x07 -> parity bit=1; byte 0x03 -> parity bit=0;
//    frame=44 cycles.
//  5 tx_enable dropped during DATA of byte 0x55 with 2 more bytes queued ->
//    0x55 completes; no rd_en until tx_enable=1, then the next byte is sent.
//  6 reset asserted mid-DATA -> tx=1 within the same cycle, busy=0; after
//    release the next queued byte is sent intact after the 2-cycle settle.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx_if
//  Description : FIFO read port + serial TX handshake bundle for fifo_uart_tx.
//                master = FIFO / control side, slave = the serialiser.
//  Revision    : 1.0  initial release
// ============================================================================
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
) ();
    logic             tx_enable;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd_en;
    logic             tx;
    logic             busy;
    logic             frame_done;

    modport master (
        output tx_enable,
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  tx_enable,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output tx,
        output busy,
        output frame_done
    );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Pops bytes from a synchronous FIFO and serialises each one as
//                an async UART frame (start, WIDTH data LSB first, optional
//                even parity, one stop). All outputs registered.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int DIV_WIDTH    = 16,
    parameter int PARITY_EN    = 0
) (
    input  wire logic      clk,
    input  wire logic      reset,
    fifo_uart_tx_if.slave  bus
);

    localparam int                   c_BIT_W     = $clog2(WIDTH + 1);
    localparam logic [c_BIT_W-1:0]   c_LAST_BIT  = c_BIT_W'(WIDTH - 1);
    localparam logic [DIV_WIDTH-1:0] c_BAUD_LAST = DIV_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [DIV_WIDTH-1:0] c_BAUD_PRE  = DIV_WIDTH'(CLKS_PER_BIT - 2);
    localparam logic [DIV_WIDTH-1:0] c_BAUD_ONE  = DIV_WIDTH'(1);
    localparam logic [1:0]           c_SETTLED   = 2'd2;
    localparam bit                   c_PARITY    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_shift;
    logic                 r_parity;
    logic [DIV_WIDTH-1:0] r_baud;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [1:0]           r_settle;
    logic                 r_tx;
    logic                 r_rd_en;
    logic                 r_busy;
    logic                 r_frame_done;

    logic                 w_bit_end;
    logic                 w_pre_end;
    logic                 w_settled;
    logic [WIDTH-1:0]     w_shift_next;

    assign w_bit_end    = (r_baud == c_BAUD_LAST);
    assign w_pre_end    = (r_baud == c_BAUD_PRE);
    assign w_settled    = (r_settle == c_SETTLED);
    assign w_shift_next = r_shift >> 1;

    // Frame sequencer: pop, load, then shift out start/data/parity/stop bits.
    // tx is updated one edge ahead so the registered line changes exactly on
    // each bit boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_baud       <= '0;
            r_bit_cnt    <= '0;
            r_settle     <= 2'd0;
            r_tx         <= 1'b1;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_en      <= 1'b0;
            r_frame_done <= 1'b0;
            // fifo_empty is not trustworthy straight out of reset
            if (!w_settled) begin
                r_settle <= r_settle + 2'd1;
            end
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_settled && bus.tx_enable && !bus.fifo_empty) begin
                        r_state <= S_POP;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_POP: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift   <= bus.fifo_data;
                    r_parity  <= 1'b0;
                    r_baud    <= '0;
                    r_bit_cnt <= '0;
                    r_tx      <= 1'b0;
                    r_state   <= S_START;
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud   <= '0;
                        r_shift  <= w_shift_next;
                        r_parity <= r_parity ^ r_shift[0];
                        if (r_bit_cnt == c_LAST_BIT) begin
                            if (c_PARITY) begin
                                r_tx    <= r_parity ^ r_shift[0];
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tx      <= w_shift_next[0];
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                S_STOP: begin
                    // registered pulse lands on the final stop cycle
                    if (w_pre_end) begin
                        r_frame_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_baud  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx         = r_tx;
    assign bus.fifo_rd_en = r_rd_en;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Bench for fifo_uart_tx. Two instances (no parity / even
//                parity, 4 clocks per bit) each fed by a queue-based FIFO model
//                with a registered empty flag and one-cycle read latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_uart_tx;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    typedef struct {
        bit         pe;
        logic [7:0] data;
        logic       par;
        int         gap;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_uart_tx_if #(.WIDTH(8)) b0 ();
    fifo_uart_tx_if #(.WIDTH(8)) b1 ();

    fifo_uart_tx #(
        .WIDTH(8), .CLKS_PER_BIT(4), .DIV_WIDTH(16), .PARITY_EN(0)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    fifo_uart_tx #(
        .WIDTH(8), .CLKS_PER_BIT(4), .DIV_WIDTH(16), .PARITY_EN(1)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    exp_t       sb0[$];
    exp_t       sb1[$];

    int checks = 0;
    int errors = 0;
    int frames[2];
    int rd_cnt[2];
    int viol[2];
    bit prev_rd0 = 1'b0;
    bit prev_rd1 = 1'b0;

    // FIFO models: pop on rd_en, data valid next cycle, empty flag registered
    always @(posedge clk) begin
        if (b0.fifo_rd_en && fq0.size() > 0) b0.fifo_data <= fq0.pop_front();
        b0.fifo_empty <= (fq0.size() == 0);
        if (b1.fifo_rd_en && fq1.size() > 0) b1.fifo_data <= fq1.pop_front();
        b1.fifo_empty <= (fq1.size() == 0);
    end

    // Pop-strobe monitor: counts pulses, flags pops on empty or >1 cycle wide
    always @(negedge clk) begin
        if (b0.fifo_rd_en) begin
            rd_cnt[0]++;
            if (b0.fifo_empty || prev_rd0) viol[0]++;
        end
        if (b1.fifo_rd_en) begin
            rd_cnt[1]++;
            if (b1.fifo_empty || prev_rd1) viol[1]++;
        end
        prev_rd0 = b0.fifo_rd_en;
        prev_rd1 = b1.fifo_rd_en;
    end

    bit   sel = 1'b0;
    logic m_tx, m_fd, m_busy, m_rd;
    assign m_tx   = sel ? b1.tx         : b0.tx;
    assign m_fd   = sel ? b1.frame_done : b0.frame_done;
    assign m_busy = sel ? b1.busy       : b0.busy;
    assign m_rd   = sel ? b1.fifo_rd_en : b0.fifo_rd_en;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input bit s, input logic [7:0] d, input logic p);
        exp_t e;
        e.data = d;
        e.par  = p;
        if (s) begin
            fq1.push_back(d);
            sb1.push_back(e);
        end else begin
            fq0.push_back(d);
            sb0.push_back(e);
        end
    endtask

    // Wait (bounded) for a start bit, then check every bit cell of the frame
    task automatic expect_frame(input bit s, input int gap);
        exp_t e;
        int   waited;
        bit   found;
        int   nbits;
        logic expb;
        logic badv;
        bit   bitbad;
        bit   fdbad;
        bit   bsbad;
        sel = s;
        if ((s && sb1.size() == 0) || (!s && sb0.size() == 0)) begin
            chk("scoreboard_underrun", 1, 0);
            return;
        end
        if (s) e = sb1.pop_front();
        else   e = sb0.pop_front();
        waited = 0;
        found  = 1'b0;
        while (!found && waited <= 200) begin
            @(negedge clk);
            if (m_tx == 1'b0) found = 1'b1;
            else              waited++;
        end
        if (!found) begin
            chk($sformatf("start_timeout_%02h", e.data), 0, 1);
            return;
        end
        frames[s]++;
        chk($sformatf("rd_count_%02h", e.data), rd_cnt[s], frames[s]);
        if (gap >= 0) chk($sformatf("idle_gap_%02h", e.data), waited, gap);
        nbits = s ? 11 : 10;
        fdbad = 1'b0;
        bsbad = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)           expb = 1'b0;
            else if (b <= 8)      expb = e.data[b-1];
            else if (s && b == 9) expb = e.par;
            else                  expb = 1'b1;
            bitbad = 1'b0;
            badv   = expb;
            for (int c = 0; c < 4; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (m_tx !== expb && !bitbad) begin
                    bitbad = 1'b1;
                    badv   = m_tx;
                end
                if (m_fd !== ((b == nbits - 1) && (c == 3))) fdbad = 1'b1;
                if (m_busy !== 1'b1) bsbad = 1'b1;
            end
            chk($sformatf("frame_%02h_bit%0d", e.data, b), int'(badv), int'(expb));
        end
        chk($sformatf("frame_done_timing_%02h", e.data), int'(fdbad), 0);
        chk($sformatf("busy_in_frame_%02h", e.data), int'(bsbad), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int  rc;
        bit  txlow;
        bit  busyhi;
        bit  found;
        int  waited;

        // {parity instance, byte, expected parity bit, expected idle gap}
        vecs[0] = '{1'b0, 8'hA5, 1'b0, -1};
        vecs[1] = '{1'b0, 8'h01, 1'b0,  3};
        vecs[2] = '{1'b0, 8'h80, 1'b0,  3};
        vecs[3] = '{1'b0, 8'hFF, 1'b0,  3};
        vecs[4] = '{1'b1, 8'h07, 1'b1, -1};
        vecs[5] = '{1'b1, 8'h03, 1'b0,  3};

        reset = 1'b0;
        b0.tx_enable = 1'b1;
        b1.tx_enable = 1'b1;

        // Reset state and quiet idle with an empty FIFO
        repeat (3) @(negedge clk);
        chk("rst_tx0",   int'(b0.tx),         1);
        chk("rst_busy0", int'(b0.busy),       0);
        chk("rst_rd0",   int'(b0.fifo_rd_en), 0);
        chk("rst_fd0",   int'(b0.frame_done), 0);
        chk("rst_tx1",   int'(b1.tx),         1);
        chk("rst_busy1", int'(b1.busy),       0);
        reset = 1'b1;
        txlow  = 1'b0;
        busyhi = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b0.tx !== 1'b1 || b1.tx !== 1'b1) txlow = 1'b1;
            if (b0.busy !== 1'b0 || b1.busy !== 1'b0) busyhi = 1'b1;
        end
        chk("idle_rd_cnt0", rd_cnt[0], 0);
        chk("idle_rd_cnt1", rd_cnt[1], 0);
        chk("idle_tx_low",  int'(txlow),  0);
        chk("idle_busy",    int'(busyhi), 0);

        // Table-driven frames; each batch of same-instance entries is queued at once
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || vecs[i].pe != vecs[i-1].pe) begin
                for (int j = i; j < 6 && vecs[j].pe == vecs[i].pe; j++)
                    push(vecs[j].pe, vecs[j].data, vecs[j].par);
            end
            expect_frame(vecs[i].pe, vecs[i].gap);
        end

        // tx_enable dropped during DATA: frame finishes, no further pops
        push(1'b0, 8'h55, 1'b0);
        push(1'b0, 8'h33, 1'b0);
        push(1'b0, 8'h0F, 1'b0);
        fork
            expect_frame(1'b0, -1);
            begin
                repeat (16) @(negedge clk);
                b0.tx_enable = 1'b0;
            end
        join
        rc    = rd_cnt[0];
        txlow = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b0.tx !== 1'b1) txlow = 1'b1;
        end
        chk("disabled_no_pop",  rd_cnt[0], rc);
        chk("disabled_tx_high", int'(txlow), 0);
        b0.tx_enable = 1'b1;
        expect_frame(1'b0, -1);
        expect_frame(1'b0, 3);

        // Reset mid-DATA: abort at once, lost byte not re-popped
        push(1'b0, 8'hC3, 1'b0);
        push(1'b0, 8'h3C, 1'b0);
        sel    = 1'b0;
        found  = 1'b0;
        waited = 0;
        while (!found && waited <= 200) begin
            @(negedge clk);
            if (b0.tx == 1'b0) found = 1'b1;
            else               waited++;
        end
        chk("abort_start_seen", int'(found), 1);
        repeat (10) @(negedge clk);
        chk("pre_abort_busy", int'(b0.busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_tx",   int'(b0.tx),         1);
        chk("abort_busy", int'(b0.busy),       0);
        chk("abort_rd",   int'(b0.fifo_rd_en), 0);
        void'(sb0.pop_front());
        frames[0]++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rc = rd_cnt[0];
        repeat (2) @(negedge clk);
        chk("settle_no_pop", rd_cnt[0], rc);
        expect_frame(1'b0, -1);

        repeat (10) @(negedge clk);
        chk("rd_total0", rd_cnt[0], frames[0]);
        chk("rd_total1", rd_cnt[1], frames[1]);
        chk("rd_violations0", viol[0], 0);
        chk("rd_violations1", viol[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
